// File: rtl/round_sequencer.sv
// Match-level round sequencer for the two-player bomb game; optional pause via ROUND_SEQUENCER_PAUSE_EN.
// Latency: every output is registered and changes on the clk edge where the state changes.
// Backpressure: none; tick/start/win/pause are sampled every cycle and ignored in states that do not use them.
module round_sequencer #(
    parameter int WINS_TO_MATCH   = 3,
    parameter int COUNTDOWN_TICKS = 3,
    parameter int ROUND_TICKS     = 60,
    parameter int OVER_TICKS      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
`ifdef ROUND_SEQUENCER_PAUSE_EN
    input  logic       pause,
`endif
    input  logic       a_win,
    input  logic       b_win,
    output logic       round_rst,
    output logic       a_move_en,
    output logic       b_move_en,
    output logic [3:0] score_a,
    output logic [3:0] score_b,
    output logic [7:0] timer,
    output logic [2:0] state,
    output logic [1:0] match_winner
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_COUNTDOWN  = 3'd1,
        S_PLAY       = 3'd2,
        S_ROUND_OVER = 3'd3,
        S_MATCH_OVER = 3'd4,
        S_PAUSED     = 3'd5
    } state_t;

    localparam logic [3:0] WINS   = 4'(WINS_TO_MATCH);
    localparam logic [7:0] CD_T   = 8'(COUNTDOWN_TICKS);
    localparam logic [7:0] PLAY_T = 8'(ROUND_TICKS);
    localparam logic [7:0] OVER_T = 8'(OVER_TICKS);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [3:0] score_a_q, score_a_d;
    logic [3:0] score_b_q, score_b_d;
    logic [1:0] winner_q, winner_d;
    logic       round_rst_q;
    logic       move_en_q;
    logic       pause_req;

`ifdef ROUND_SEQUENCER_PAUSE_EN
    assign pause_req = pause;
`else
    // Without the pause feature PAUSED is never entered.
    assign pause_req = 1'b0;
`endif

    // Next-state, timer, score and winner update for one cycle.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        score_a_d = score_a_q;
        score_b_d = score_b_q;
        winner_d  = winner_q;
        case (state_q)
            S_IDLE, S_MATCH_OVER: begin
                if (start) begin
                    state_d   = S_COUNTDOWN;
                    timer_d   = CD_T;
                    score_a_d = 4'd0;
                    score_b_d = 4'd0;
                    winner_d  = 2'd0;
                end
            end
            S_COUNTDOWN: begin
                if (tick) begin
                    if (timer_q == 8'd1) begin
                        state_d = S_PLAY;
                        timer_d = PLAY_T;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            end
            S_PLAY: begin
                // A win on the final tick still counts as a win; a simultaneous win is a draw.
                // Round-ending events take precedence over a pause request in the same cycle.
                if (a_win || b_win || (tick && timer_q == 8'd1)) begin
                    state_d = S_ROUND_OVER;
                    timer_d = OVER_T;
                    if (a_win && !b_win && score_a_q != WINS) score_a_d = score_a_q + 4'd1;
                    if (b_win && !a_win && score_b_q != WINS) score_b_d = score_b_q + 4'd1;
                end else if (pause_req) begin
                    state_d = S_PAUSED;
                end else if (tick) begin
                    timer_d = timer_q - 8'd1;
                end
            end
            S_ROUND_OVER: begin
                if (tick) begin
                    if (timer_q == 8'd1) begin
                        if (score_a_q == WINS || score_b_q == WINS) begin
                            state_d  = S_MATCH_OVER;
                            timer_d  = 8'd0;
                            winner_d = (score_a_q == WINS) ? 2'd1 : 2'd2;
                        end else begin
                            state_d = S_COUNTDOWN;
                            timer_d = CD_T;
                        end
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            end
            S_PAUSED: begin
                // Timer frozen; ticks and win inputs are ignored until resumed.
                if (pause_req) state_d = S_PLAY;
            end
            default: begin
                state_d = S_IDLE;
                timer_d = 8'd0;
            end
        endcase
    end

    // State and datapath registers; datapath enables are decoded from the next state so they track state with no lag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            timer_q     <= 8'd0;
            score_a_q   <= 4'd0;
            score_b_q   <= 4'd0;
            winner_q    <= 2'd0;
            round_rst_q <= 1'b1;
            move_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            score_a_q   <= score_a_d;
            score_b_q   <= score_b_d;
            winner_q    <= winner_d;
            round_rst_q <= !(state_d == S_PLAY || state_d == S_PAUSED);
            move_en_q   <= (state_d == S_PLAY);
        end
    end

    assign state        = state_q;
    assign timer        = timer_q;
    assign score_a      = score_a_q;
    assign score_b      = score_b_q;
    assign match_winner = winner_q;
    assign round_rst    = round_rst_q;
    assign a_move_en    = move_en_q;
    assign b_move_en    = move_en_q;

endmodule
